// File: rtl/usb_stream_rx_pkg.sv
// usb_stream_rx_pkg: shared FSM encoding and FX2 constants for the EP2 OUT stream receiver
package usb_stream_rx_pkg;
  localparam int DATA_W = 16;
  localparam logic [1:0] EP2_ADDR = 2'b00;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_OE, S_READ} state_t;
endpackage

// File: rtl/rx_buffer_fifo.sv
// rx_buffer_fifo: first-word-fall-through receive buffer with free-slot count
module rx_buffer_fifo
  import usb_stream_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic                          i_rd,
  output logic                          o_empty,
  output logic [DATA_W-1:0]             o_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_free
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW + 1)'(FIFO_DEPTH);
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_rd_ok, w_wr_ok;
  // a pop on the same edge frees the slot, so a full buffer may still take a write
  assign w_rd_ok = i_rd && (r_cnt != '0);
  assign w_wr_ok = i_wr && ((r_cnt != L_DEPTH) || w_rd_ok);
  assign o_empty = (r_cnt == '0);
  assign o_data  = o_empty ? '0 : r_mem[r_rp];
  assign o_free  = L_DEPTH - r_cnt;
  // storage array, no reset needed since the output is masked while empty
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wp] <= i_wdata;
  end
  // pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + AW'(1);
      if (w_rd_ok) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW + 1)'(w_wr_ok) - (AW + 1)'(w_rd_ok);
    end
  end
endmodule

// File: rtl/usb_stream_rx.sv
// usb_stream_rx: FX2 slave-FIFO EP2 OUT reader feeding an FWFT buffer with word counter
module usb_stream_rx
  import usb_stream_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 i_stream_clk,
  input  logic                 i_stream_rst,
  input  logic                 i_enable,
  input  logic                 i_stream_empty_n,
  input  logic [DATA_W-1:0]    i_stream_data_in,
  output logic [1:0]           o_stream_fifoaddr,
  output logic                 o_stream_sloe_n,
  output logic                 o_stream_slrd_n,
  output logic                 o_active,
  input  logic                 i_fifo_read,
  output logic                 o_fifo_empty,
  output logic [DATA_W-1:0]    o_fifo_data,
  output logic [CNT_WIDTH-1:0] o_word_cnt
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  state_t r_state;
  logic r_sloe_n, r_slrd_n, r_active;
  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic [FW-1:0] w_free;
  logic w_go, w_accept;
  // two free slots cover the word already strobed plus the next one
  assign w_go     = i_enable && i_stream_empty_n && (w_free >= FW'(2));
  assign w_accept = !r_slrd_n && i_stream_empty_n;
  assign o_stream_fifoaddr = EP2_ADDR;
  assign o_stream_sloe_n   = r_sloe_n;
  assign o_stream_slrd_n   = r_slrd_n;
  assign o_active          = r_active;
  assign o_word_cnt        = r_word_cnt;
  rx_buffer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_buf (
    .i_clk   (i_stream_clk),
    .i_rst   (i_stream_rst),
    .i_wr    (w_accept),
    .i_wdata (i_stream_data_in),
    .i_rd    (i_fifo_read),
    .o_empty (o_fifo_empty),
    .o_data  (o_fifo_data),
    .o_free  (w_free)
  );
  // pin-ownership sequencer with registered strobes
  always_ff @(posedge i_stream_clk or posedge i_stream_rst) begin
    if (i_stream_rst) begin
      r_state  <= S_IDLE;
      r_sloe_n <= 1'b1;
      r_slrd_n <= 1'b1;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) begin
          r_state  <= S_ADDR;
          r_active <= 1'b1;
        end
        S_ADDR: begin
          r_state  <= S_OE;
          r_sloe_n <= 1'b0;
        end
        S_OE: begin
          r_state  <= S_READ;
          r_slrd_n <= !w_go;
        end
        S_READ: if (w_go) r_slrd_n <= 1'b0;
        else begin
          r_state  <= S_IDLE;
          r_slrd_n <= 1'b1;
          r_sloe_n <= 1'b1;
          r_active <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // accepted-word counter, wraps naturally
  always_ff @(posedge i_stream_clk or posedge i_stream_rst) begin
    if (i_stream_rst) r_word_cnt <= '0;
    else if (w_accept) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_usb_stream_rx.sv
// tb_usb_stream_rx: FX2 source model plus FIFO scoreboard around usb_stream_rx
module tb_usb_stream_rx;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic emn = 1'b0;
  logic [15:0] din = 16'h0;
  logic rd = 1'b0;
  logic [1:0] faddr;
  logic sloe_n, slrd_n, active, femp;
  logic [15:0] fdata;
  logic [31:0] wcnt;
  int checks = 0;
  int errors = 0;
  logic [15:0] fx_q [$];
  logic [15:0] mq [$];
  logic fx_gate = 1'b1;
  logic [31:0] exp_cnt = 32'h0;
  typedef struct {
    logic en, rd, act, oe_n, rd_n, emp;
    logic [15:0] data;
  } row_t;
  row_t tbl [13];

  usb_stream_rx #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .i_stream_clk      (clk),
    .i_stream_rst      (rst),
    .i_enable          (en),
    .i_stream_empty_n  (emn),
    .i_stream_data_in  (din),
    .o_stream_fifoaddr (faddr),
    .o_stream_sloe_n   (sloe_n),
    .o_stream_slrd_n   (slrd_n),
    .o_active          (active),
    .i_fifo_read       (rd),
    .o_fifo_empty      (femp),
    .o_fifo_data       (fdata),
    .o_word_cnt        (wcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  function automatic void fx_drive();
    emn = fx_gate && (fx_q.size() != 0);
    din = (fx_q.size() != 0) ? fx_q[0] : 16'h0;
  endfunction

  task automatic fx_load(input int n, input logic [15:0] base);
    fx_q.delete();
    for (int i = 0; i < n; i++) fx_q.push_back(base + 16'(i));
    fx_drive();
  endtask

  // one clock: sample at negedge, advance models just after the rising edge
  task automatic cyc();
    logic acc, pop, vd;
    logic [15:0] w;
    @(negedge clk);
    acc = !slrd_n && emn;
    vd  = !slrd_n && !emn;
    pop = rd && (mq.size() != 0);
    w   = din;
    if (!slrd_n) chk("strobe_owns_bus", 32'(!sloe_n && active), 32'd1);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      void'(fx_q.pop_front());
      mq.push_back(w);
      exp_cnt = exp_cnt + 32'd1;
    end
    fx_drive();
    if (vd) chk("void_to_idle", 32'(active), 32'd0);
    chk("no_overflow", 32'(mq.size() <= DEPTH), 32'd1);
    chk("fifo_empty", 32'(femp), 32'(mq.size() == 0));
    chk("fifo_data", 32'(fdata), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("word_cnt", wcnt, exp_cnt);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0};
    for (int i = 3; i <= 10; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000 + 16'(i - 3)};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0};

    fx_drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sloe", 32'(sloe_n), 32'd1);
    chk("rst_slrd", 32'(slrd_n), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_empty", 32'(femp), 32'd1);
    chk("rst_data", 32'(fdata), 32'd0);
    chk("rst_cnt", wcnt, 32'd0);
    chk("fifoaddr", 32'(faddr), 32'd0);
    rst = 1'b0;
    repeat (2) cyc();

    fx_load(8, 16'h1000);
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en;
      rd = tbl[i].rd;
      cyc();
      chk($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].act));
      chk($sformatf("tbl%0d_sloe", i), 32'(sloe_n), 32'(tbl[i].oe_n));
      chk($sformatf("tbl%0d_slrd", i), 32'(slrd_n), 32'(tbl[i].rd_n));
      chk($sformatf("tbl%0d_empty", i), 32'(femp), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_data", i), 32'(fdata), 32'(tbl[i].data));
    end
    chk("burst_cnt", wcnt, 32'd8);

    rd = 1'b0;
    fx_load(10, 16'h2000);
    repeat (15) cyc();
    chk("stall_cnt", wcnt, 32'd12);
    chk("stall_slrd", 32'(slrd_n), 32'd1);
    chk("stall_idle", 32'(active), 32'd0);
    rd = 1'b1;
    repeat (2) cyc();
    rd = 1'b0;
    repeat (10) cyc();
    chk("resume_cnt", wcnt, 32'd14);
    en = 1'b0;
    rd = 1'b1;
    repeat (6) cyc();

    fx_load(3, 16'h3000);
    en = 1'b1;
    repeat (12) cyc();
    chk("flagdrop_cnt", wcnt, 32'd17);
    chk("flagdrop_idle", 32'(active), 32'd0);

    fx_load(20, 16'h4000);
    repeat (7) cyc();
    chk("midburst_slrd", 32'(slrd_n), 32'd0);
    en = 1'b0;
    cyc();
    chk("dis_slrd", 32'(slrd_n), 32'd1);
    chk("dis_sloe", 32'(sloe_n), 32'd1);
    chk("dis_active", 32'(active), 32'd0);
    repeat (3) cyc();

    en = 1'b1;
    repeat (6) cyc();
    chk("preRst_slrd", 32'(slrd_n), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("arst_sloe", 32'(sloe_n), 32'd1);
    chk("arst_slrd", 32'(slrd_n), 32'd1);
    chk("arst_active", 32'(active), 32'd0);
    chk("arst_empty", 32'(femp), 32'd1);
    chk("arst_data", 32'(fdata), 32'd0);
    chk("arst_cnt", wcnt, 32'd0);
    mq.delete();
    exp_cnt = 32'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("post_rst_addr", 32'(slrd_n), 32'd1);
    cyc();
    chk("post_rst_oe", 32'(slrd_n), 32'd1);
    cyc();
    chk("post_rst_read", 32'(slrd_n), 32'd0);

    en = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    force dut.r_word_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_word_cnt;
    @(posedge clk);
    #1;
    exp_cnt = 32'hFFFF_FFFE;
    fx_load(3, 16'h5000);
    en = 1'b1;
    repeat (10) cyc();
    chk("wrap_cnt", wcnt, 32'd1);

    for (int k = 0; k < 3000; k++) begin
      int rp;
      rp = ((k / 200) % 3 == 0) ? 1 : ((k / 200) % 3 == 1) ? 3 : 15;
      en = ($urandom_range(0, 15) != 0);
      rd = ($urandom_range(0, rp) != 0);
      fx_gate = ($urandom_range(0, 7) != 0);
      while (fx_q.size() < 4) fx_q.push_back(16'($urandom));
      fx_drive();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
